bootrom_loader_seq: RTL and testbench
=====================================

Name: bootrom_loader_seq

Overview:
Sequences the one-time boot load of the 32 KB ROM image into external SRAM before the machine runs. Accepts a byte stream from the flash/SPI reader (valid/ready), then drives the SRAM controller's romwrite_addr/romwrite_data/romwrite_wr port with setup/strobe/recover timing. Raises rom_initialised when the load completes, which hands the SRAM turn scheme back to CPU/ASIC. Holds the CPU in reset throughout the load.

Parameters:
ROM_BASE, 19'h40000, SRAM byte address of ROM byte 0 (ROM window {4'b1000, romaddr[14:0]}).
ROM_SIZE, 32768, number of image bytes written; legal range 1..32768.
WR_CYCLES, 2, clock cycles romwrite_wr is held high per byte; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  level; begin load when sampled high in IDLE
in_data  in  8  image byte from flash reader
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte this cycle
romwrite_addr  out  19  SRAM write address
romwrite_data  out  8  SRAM write data
romwrite_wr  out  1  SRAM write strobe, active high
rom_initialised  out  1  sticky; image fully loaded
cpu_rst_n  out  1  CPU reset, low until rom_initialised
busy  out  1  high from accepting start until DONE/ERROR
load_error  out  1  sticky checksum failure (see Optional Feature)

Behaviour:
- Reset values: in_ready=0, romwrite_addr=ROM_BASE, romwrite_data=0, romwrite_wr=0, rom_initialised=0, cpu_rst_n=0, busy=0, load_error=0; byte counter=0.
- States: IDLE, WAIT_BYTE, SETUP, STROBE, RECOVER, DONE, ERROR.
- IDLE: start=1 -> WAIT_BYTE, busy=1, counter=0, addr=ROM_BASE.
- WAIT_BYTE: in_ready=1 (registered, asserted only in this state). in_valid&&in_ready -> latch in_data into romwrite_data, -> SETUP. Otherwise stay; no timeout.
- SETUP: 1 cycle, addr/data stable, wr=0 -> STROBE.
- STROBE: wr=1 for exactly WR_CYCLES cycles; addr/data unchanged -> RECOVER.
- RECOVER: 1 cycle, wr=0, addr/data held. Then if counter==ROM_SIZE-1 -> DONE; else counter++, addr++ -> WAIT_BYTE.
- Throughput: at most one byte per WR_CYCLES+3 cycles.
- Address arithmetic: 19-bit, addr=ROM_BASE+counter; counter 15 bits + terminal compare (no wrap at 32768).
- DONE: rom_initialised=1, cpu_rst_n=1, busy=0, in_ready=0, wr=0. Terminal until rst; start ignored.
- romwrite_wr never high while rom_initialised=1.
- rst mid-load: immediate return to reset values; partially written SRAM left as-is; reload only on next start.
- in_valid while not in WAIT_BYTE: ignored, byte not consumed (in_ready=0).

Optional Feature:
BOOTROM_CHECKSUM_EN. With: after ROM_SIZE bytes, RECOVER -> WAIT_BYTE once more to accept a trailing checksum byte (not written to SRAM, no SETUP/STROBE); 8-bit sum of all ROM_SIZE+1 bytes mod 256 must be 0 -> DONE; else -> ERROR: load_error=1, busy=0, rom_initialised=0, cpu_rst_n=0, terminal until rst. Without: exactly ROM_SIZE bytes, load_error tied 0, ERROR state unreachable/absent.

Decomposition:
- Package bootrom_pkg: state encoding enum, ROM_BASE_DEFAULT=19'h40000, ROM_SIZE_DEFAULT=32768.
- Single module; no sub-module. The strobe timer (WR_CYCLES down-counter) stays inline.

Test Plan:
- Reset check: rst pulse mid-cycle (async) -> all outputs at reset values within same cycle, cpu_rst_n=0.
- ROM_SIZE=4, WR_CYCLES=2, bytes A5,5A,00,FF with in_valid always 1 -> writes to 40000..40003 with matching data, wr high exactly 2 cycles each, 5-cycle byte spacing, rom_initialised=1 after 4th RECOVER.
- Backpressure/stall: in_valid gaps of 0..7 random cycles -> no duplicate or dropped bytes, in_ready only in WAIT_BYTE, addr/data stable across SETUP..RECOVER.
- rst asserted during STROBE of byte 2 then start again -> restart at 40000, counter 0, full 4-byte load completes.
- start toggled after DONE and in_valid held high -> no further romwrite_wr, rom_initialised stays 1.
- BOOTROM_CHECKSUM_EN, bytes 01,02,03,04 + F6 -> DONE; trailing FF instead -> ERROR, load_error=1, cpu_rst_n=0, only 4 SRAM writes seen.

Source files
------------

// File: rtl/bootrom_pkg.sv
// Shared types and defaults for the boot ROM loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bootrom_pkg;

  localparam logic [18:0] ROM_BASE_DEFAULT  = 19'h40000;
  localparam int          ROM_SIZE_DEFAULT  = 32768;
  localparam int          WR_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/bootrom_loader_seq_if.sv
// Byte stream in / SRAM ROM-write port out, grouped for the loader.
// Latency: n/a (wires only).
// Backpressure: in_ready is driven by the loader (master side).
interface bootrom_loader_seq_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] romwrite_addr;
  logic [7:0]  romwrite_data;
  logic        romwrite_wr;

  // Loader side: consumes the byte stream, drives the SRAM write port.
  modport master (
    input  in_data, in_valid,
    output in_ready, romwrite_addr, romwrite_data, romwrite_wr
  );

  // Environment side: flash reader feeding bytes, SRAM controller observing writes.
  modport slave (
    output in_data, in_valid,
    input  in_ready, romwrite_addr, romwrite_data, romwrite_wr
  );

endinterface

// File: rtl/bootrom_loader_seq.sv
// Copies the ROM image byte stream into SRAM with setup/strobe/recover timing, holding the CPU in reset.
// Latency: WR_CYCLES+3 cycles per byte minimum; rom_initialised rises the cycle after the last RECOVER.
// Backpressure: in_ready high only while waiting for a byte; optional trailing checksum via BOOTROM_CHECKSUM_EN.
module bootrom_loader_seq
  import bootrom_pkg::*;
#(
  parameter logic [18:0] ROM_BASE  = ROM_BASE_DEFAULT,
  parameter int          ROM_SIZE  = ROM_SIZE_DEFAULT,
  parameter int          WR_CYCLES = WR_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  bootrom_loader_seq_if.master bus,
  input  logic                 start,
  output logic                 rom_initialised,
  output logic                 cpu_rst_n,
  output logic                 busy,
  output logic                 load_error
);

  // Strobe timer only needs to count down from WR_CYCLES-1.
  localparam int          TMR_W    = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [14:0] LAST_CNT = 15'(ROM_SIZE - 1);

  state_t           state;
  logic [14:0]      cnt;
  logic [TMR_W-1:0] tmr;

`ifdef BOOTROM_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_phase;
  logic       load_error_q;
  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  // Load sequencer: every output is a register updated on state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      tmr               <= '0;
      bus.in_ready      <= 1'b0;
      bus.romwrite_addr <= ROM_BASE;
      bus.romwrite_data <= 8'h00;
      bus.romwrite_wr   <= 1'b0;
      rom_initialised   <= 1'b0;
      cpu_rst_n         <= 1'b0;
      busy              <= 1'b0;
`ifdef BOOTROM_CHECKSUM_EN
      sum               <= 8'h00;
      chk_phase         <= 1'b0;
      load_error_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state             <= ST_WAIT_BYTE;
            busy              <= 1'b1;
            cnt               <= '0;
            bus.romwrite_addr <= ROM_BASE;
            bus.in_ready      <= 1'b1;
`ifdef BOOTROM_CHECKSUM_EN
            sum               <= 8'h00;
            chk_phase         <= 1'b0;
`endif
          end
        end

        ST_WAIT_BYTE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
`ifdef BOOTROM_CHECKSUM_EN
            if (chk_phase) begin
              // Trailing checksum byte: never written to SRAM.
              busy <= 1'b0;
              if ((sum + bus.in_data) == 8'h00) begin
                state           <= ST_DONE;
                rom_initialised <= 1'b1;
                cpu_rst_n       <= 1'b1;
              end else begin
                state        <= ST_ERROR;
                load_error_q <= 1'b1;
              end
            end else begin
              sum               <= sum + bus.in_data;
              bus.romwrite_data <= bus.in_data;
              state             <= ST_SETUP;
            end
`else
            bus.romwrite_data <= bus.in_data;
            state             <= ST_SETUP;
`endif
          end
        end

        ST_SETUP: begin
          bus.romwrite_wr <= 1'b1;
          tmr             <= TMR_W'(WR_CYCLES - 1);
          state           <= ST_STROBE;
        end

        ST_STROBE: begin
          if (tmr == '0) begin
            bus.romwrite_wr <= 1'b0;
            state           <= ST_RECOVER;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        ST_RECOVER: begin
          if (cnt == LAST_CNT) begin
`ifdef BOOTROM_CHECKSUM_EN
            chk_phase    <= 1'b1;
            bus.in_ready <= 1'b1;
            state        <= ST_WAIT_BYTE;
`else
            state           <= ST_DONE;
            rom_initialised <= 1'b1;
            cpu_rst_n       <= 1'b1;
            busy            <= 1'b0;
`endif
          end else begin
            cnt               <= cnt + 15'd1;
            bus.romwrite_addr <= bus.romwrite_addr + 19'd1;
            bus.in_ready      <= 1'b1;
            state             <= ST_WAIT_BYTE;
          end
        end

        // DONE and ERROR are terminal until rst; start and in_valid are ignored.
        default: begin
          bus.in_ready    <= 1'b0;
          bus.romwrite_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bootrom_loader_seq.sv
// Self-checking bench for bootrom_loader_seq with ROM_SIZE=4, WR_CYCLES=2.
// Latency: byte spacing and rom_initialised timing are checked against the sequencing rules.
// Backpressure: random in_valid gaps; a write monitor pops expected writes from a scoreboard queue.
module tb_bootrom_loader_seq;
  import bootrom_pkg::*;

  localparam int          RS   = 4;
  localparam int          WC   = 2;
  localparam logic [18:0] BASE = 19'h40000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic rom_init, cpu_rst_n, busy, load_error;

  bootrom_loader_seq_if bus();

  bootrom_loader_seq #(.ROM_BASE(BASE), .ROM_SIZE(RS), .WR_CYCLES(WC)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .start           (start),
    .rom_initialised (rom_init),
    .cpu_rst_n       (cpu_rst_n),
    .busy            (busy),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0]  dat;
    int          gap;
    logic [18:0] exp_addr;
  } vec_t;
  vec_t vec [16];

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  dat;
  } wr_t;
  wr_t exp_q [$];

  int wr_count  = 0;
  int rdy_viol  = 0;
  int init_viol = 0;
  int stab_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: each rising strobe must match the scoreboard head; width and hold checked at the fall.
  logic        wr_prev = 1'b0;
  int          hi      = 0;
  logic [18:0] a0;
  logic [7:0]  d0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_prev = 1'b0;
      hi      = 0;
    end else begin
      if (bus.romwrite_wr && bus.in_ready) rdy_viol++;
      if (bus.romwrite_wr && rom_init) init_viol++;
      if (bus.romwrite_wr && !wr_prev) begin
        wr_count++;
        a0 = bus.romwrite_addr;
        d0 = bus.romwrite_data;
        hi = 1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", a0, d0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.romwrite_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.romwrite_data), 32'(e.dat));
        end
      end else if (bus.romwrite_wr) begin
        hi++;
        if (bus.romwrite_addr !== a0 || bus.romwrite_data !== d0) stab_viol++;
      end else if (wr_prev) begin
        chk("wr_width", 32'(hi), 32'(WC));
        chk("strobe_hold", 32'(stab_viol), 32'd0);
        chk("recover_hold", 32'({bus.romwrite_addr, bus.romwrite_data}), 32'({a0, d0}));
        stab_viol = 0;
      end
      wr_prev = bus.romwrite_wr;
    end
  end

  task automatic do_reset();
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte; returns at the negedge after the accepting posedge.
  task automatic send_raw(input logic [7:0] dat, input int gap, output logic ok, output int hs_cyc);
    int t;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_data  = dat;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok     = bus.in_ready;
    hs_cyc = cyc;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout: got in_ready=0 for 100 cycles, want in_ready=1");
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send(input int idx, output int hs_cyc);
    logic ok;
    send_raw(vec[idx].dat, vec[idx].gap, ok, hs_cyc);
    if (ok) exp_q.push_back({vec[idx].exp_addr, vec[idx].dat});
  endtask

  // Full load of table entries base..base+3, then completion checks.
  task automatic load(input int base, input logic spacing, input logic hold_valid);
    int   t [RS];
    int   w0;
    logic ok;
    int   dummy;
    logic [7:0] s;
    w0 = wr_count;
    s  = 8'h00;
    kick();
    for (int i = 0; i < RS; i++) begin
      send(base + i, t[i]);
      s = s + vec[base + i].dat;
    end
    if (!hold_valid) bus.in_valid = 1'b0;
    if (spacing)
      for (int i = 1; i < RS; i++) chk("byte_spacing", 32'(t[i] - t[i-1]), 32'(WC + 3));
`ifdef BOOTROM_CHECKSUM_EN
    send_raw(8'h00 - s, 0, ok, dummy);
    if (!hold_valid) bus.in_valid = 1'b0;
    chk("init_after_checksum", 32'(rom_init), 32'd1);
`else
    ok    = 1'b1;
    dummy = s;
    repeat (3) @(negedge clk);
    chk("init_early", 32'(rom_init), 32'd0);
    @(negedge clk);
    chk("init_after_last", 32'(rom_init), 32'd1);
`endif
    chk("cpu_rst_n_done", 32'(cpu_rst_n), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("load_error_done", 32'(load_error), 32'd0);
    chk("writes_per_load", 32'(wr_count - w0), 32'(RS));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_addr"}, 32'(bus.romwrite_addr), 32'(BASE));
    chk({tag, "_data"}, 32'(bus.romwrite_data), 32'd0);
    chk({tag, "_wr"}, 32'(bus.romwrite_wr), 32'd0);
    chk({tag, "_init"}, 32'(rom_init), 32'd0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish after 200000 time units, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fixed [12];
    int         fgap  [12];
    int         dummy;
    int         w0;
    int         rdy_seen;
    int         init_drop;

    fixed = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h3C, 8'hC3, 8'h81, 8'h7E};
    fgap  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 3};
    for (int i = 0; i < 12; i++) begin
      vec[i].dat      = (i >= 4 && i < 8) ? 8'($urandom_range(0, 255)) : fixed[i];
      vec[i].gap      = (i >= 4 && i < 8) ? $urandom_range(0, 7) : fgap[i];
      vec[i].exp_addr = BASE + 19'(i % 4);
    end
    for (int i = 12; i < 16; i++) begin
      vec[i].dat      = 8'(i - 11);
      vec[i].gap      = 0;
      vec[i].exp_addr = BASE + 19'(i - 12);
    end

    // Reset state.
    do_reset();
    chk_reset_values("reset");

    // Back-to-back load, in_valid always high.
    bus.in_valid = 1'b1;
    load(0, 1'b1, 1'b0);

    // Random in_valid gaps.
    do_reset();
    load(4, 1'b0, 1'b0);

    // Async reset during the strobe of the second byte, then a full reload.
    do_reset();
    kick();
    send(8, dummy);
    send(9, dummy);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("midload_rst");
    chk("midload_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(8, 1'b0, 1'b0);

    // Start toggling with in_valid held high after DONE: nothing more happens.
    w0        = wr_count;
    rdy_seen  = 0;
    init_drop = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      @(negedge clk);
      if (bus.in_ready) rdy_seen++;
      if (!rom_init) init_drop++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("done_no_writes", 32'(wr_count - w0), 32'd0);
    chk("done_no_ready", 32'(rdy_seen), 32'd0);
    chk("done_init_sticky", 32'(init_drop), 32'd0);

`ifdef BOOTROM_CHECKSUM_EN
    // 01..04 + F6 sums to zero; a trailing FF instead must end in ERROR.
    do_reset();
    load(12, 1'b0, 1'b0);
    do_reset();
    w0 = wr_count;
    begin
      logic ok;
      kick();
      for (int i = 12; i < 16; i++) send(i, dummy);
      send_raw(8'hFF, 0, ok, dummy);
      bus.in_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("err_load_error", 32'(load_error), 32'd1);
    chk("err_init", 32'(rom_init), 32'd0);
    chk("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_writes", 32'(wr_count - w0), 32'd4);
`endif

    chk("ready_during_strobe", 32'(rdy_viol), 32'd0);
    chk("wr_while_initialised", 32'(init_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
